// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port integer register file.
package regfile_pkg;

    // Clear-walk controller states
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 2;

    // Address width for a register file of the given depth (never below one bit)
    function automatic int addr_w_f(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for long-latency producers.
// A writeback clears its register, an issue sets its register; when both
// name the same register in one cycle the issue wins.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter bit ZERO_REG = 1'b1,
    localparam int ADDR_W  = addr_w_f(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    output logic [DEPTH-1:0]  busy_o
);

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_s;
    logic [DEPTH-1:0] clr_mask_s;
    logic [DEPTH-1:0] set_mask_s;
    logic [DEPTH-1:0] zero_mask_s;

    // Next busy vector: clear first, then set so a same-register issue dominates
    always_comb begin
        clr_mask_s  = clr_i ? (DEPTH'(1'b1) << clr_addr_i) : {DEPTH{1'b0}};
        set_mask_s  = set_i ? (DEPTH'(1'b1) << set_addr_i) : {DEPTH{1'b0}};
        zero_mask_s = ZERO_REG ? DEPTH'(1'b1) : {DEPTH{1'b0}};
        busy_s      = en_i ? (((busy_r & ~clr_mask_s) | set_mask_s) & ~zero_mask_s)
                           : busy_r;
    end

    // Busy vector register, cleared asynchronously on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= busy_s;
        end
    end

    assign busy_o = busy_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with optional write bypass,
// busy scoreboard and a post-reset clear walk (the array itself has no reset).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    localparam int ADDR_W  = addr_w_f(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*ADDR_W-1:0] ra_i,
    output logic [NUM_RD*DATA_W-1:0] rd_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wren_i,
    input  logic [ADDR_W-1:0]        aw_i,
    input  logic [DATA_W-1:0]        wrdata_i,
    input  logic                     issue_i,
    input  logic [ADDR_W-1:0]        issue_addr_i,
    output logic                     init_done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rf_state_e          state_r;
    rf_state_e          state_s;
    logic [ADDR_W-1:0]  clr_cnt_r;
    logic [ADDR_W-1:0]  clr_cnt_s;
    logic               init_done_r;
    logic               init_done_s;
    logic               run_s;
    logic               wr_zero_s;
    logic               wr_ok_s;
    logic [DEPTH-1:0]   busy_s;
    logic [DATA_W-1:0]  mem_r [DEPTH];

    assign run_s     = (state_r == ST_RUN);
    // Writes to x0 are dropped and never bypass
    assign wr_zero_s = ZERO_REG && (aw_i == {ADDR_W{1'b0}});
    assign wr_ok_s   = run_s && wren_i && !wr_zero_s;

    // Clear-walk next state: one entry per cycle, leave INIT after the last entry
    always_comb begin
        state_s   = state_r;
        clr_cnt_s = clr_cnt_r;
        case (state_r)
            ST_INIT: begin
                clr_cnt_s = clr_cnt_r + ADDR_W'(1);
                if (clr_cnt_r == LAST_ADDR) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_s   = ST_RUN;
                clr_cnt_s = clr_cnt_r;
            end
            default: begin
                state_s   = ST_INIT;
                clr_cnt_s = {ADDR_W{1'b0}};
            end
        endcase
        init_done_s = (state_s == ST_RUN);
    end

    // Clear-walk state, counter and registered done flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_INIT;
            clr_cnt_r   <= {ADDR_W{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            clr_cnt_r   <= clr_cnt_s;
            init_done_r <= init_done_s;
        end
    end

    assign init_done_o = init_done_r;

    // Storage array: zeroed by the walk during INIT, written by writeback in RUN
    always_ff @(posedge clk_i) begin
        if (state_r == ST_INIT) begin
            mem_r[clr_cnt_r] <= {DATA_W{1'b0}};
        end else if (wr_ok_s) begin
            mem_r[aw_i] <= wrdata_i;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (run_s),
        .clr_i      (wren_i),
        .clr_addr_i (aw_i),
        .set_i      (issue_i),
        .set_addr_i (issue_addr_i),
        .busy_o     (busy_s)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic              zero_hit_s;
        logic              byp_hit_s;
        logic              iss_hit_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_k_s;

        assign ra_s       = ra_i[k*ADDR_W +: ADDR_W];
        assign zero_hit_s = ZERO_REG && (ra_s == {ADDR_W{1'b0}});
        assign byp_hit_s  = BYPASS && wren_i && !wr_zero_s && (aw_i == ra_s);
        assign iss_hit_s  = issue_i && (issue_addr_i == ra_s);

        // Port data/busy select; a bypass hit hides busy unless a new issue targets it too
        always_comb begin
            if (!run_s) begin
                data_s   = {DATA_W{1'b0}};
                busy_k_s = 1'b0;
            end else if (zero_hit_s) begin
                data_s   = {DATA_W{1'b0}};
                busy_k_s = 1'b0;
            end else if (byp_hit_s) begin
                data_s   = wrdata_i;
                busy_k_s = iss_hit_s ? busy_s[ra_s] : 1'b0;
            end else begin
                data_s   = mem_r[ra_s];
                busy_k_s = busy_s[ra_s];
            end
        end

        assign rd_o[k*DATA_W +: DATA_W] = data_s;
        assign rd_busy_o[k]             = busy_k_s;
    end

endmodule
